fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Reader-side adapter for the async FIFO read port, on the read clock domain.
- Pops words from the FIFO using its show-ahead read interface: data is valid whenever the FIFO is not empty, and a read-enable pops the word.
- Presents the words as a valid/ready stream through a 2-entry registered buffer, so there is no combinational path from m_ready_i to r_en_o.
- Also provides a synchronous flush and a count of delivered words.

Parameters:
data_t, logic [7:0], word type; must match the FIFO data_t.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk_i  input  1  clock (FIFO read clock).
rst_i  input  1  synchronous reset, active-high.
r_data_i  input  data_t  FIFO head word; valid when r_empty_i=0.
r_empty_i  input  1  FIFO empty flag.
r_en_o  output  1  FIFO pop strobe.
m_data_o  output  data_t  stream data.
m_valid_o  output  1  stream valid.
m_ready_i  input  1  stream ready.
flush_i  input  1  discard all buffered words.
level_o  output  2  buffered words, 0..2.
xfer_cnt_o  output  CNT_WIDTH  delivered-word count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i=1 at a clock edge): count=0, m_valid_o=0, level_o=0, xfer_cnt_o=0, m_data_o=0.
- While rst_i=1, r_en_o is forced to 0 combinationally.
- Storage: 2-entry buffer with head/tail pointers (1 bit each) and count (0..2).
  - m_data_o = entry at head.
  - m_valid_o = (count != 0).
  - level_o = count.
- Pop rule: r_en_o = !rst_i && !r_empty_i && !flush_i && (count < 2).
  - Uses registered count only; m_ready_i never reaches r_en_o.
- Write: when r_en_o=1, r_data_i is written at tail at the clock edge; tail increments.
- Handshake: hs = m_valid_o && m_ready_i. On hs, head increments and xfer_cnt_o increments.
- Count update: count_next = count + r_en_o - hs.
- Simultaneous pop and hs: count unchanged; full throughput of 1 word/cycle in steady state at count=1.
- Latency: r_empty_i falls with count=0 in cycle N → r_en_o=1 in cycle N → m_valid_o=1 with that word in cycle N+1.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o and m_valid_o hold.
- Order: words leave in FIFO order; no loss, no duplication.
- Full buffer: count=2 → r_en_o=0 regardless of m_ready_i. Popping resumes the cycle after an hs drops count to 1.
- Empty FIFO: r_en_o=0; the buffer drains normally.
- Flush (flush_i=1 at an edge):
  - count, head and tail reset to 0; m_valid_o=0 next cycle.
  - r_en_o=0 in the flush cycle, so no FIFO word is consumed.
  - An hs occurring in the flush cycle still counts in xfer_cnt_o (the consumer took it).
  - xfer_cnt_o is not cleared by flush.
- Counter wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: all buffered words are lost; r_en_o=0 during reset, so no FIFO word is popped.

Test Plan:
- Reset then idle: r_empty_i=1, m_ready_i=1 for 10 cycles → r_en_o=0, m_valid_o=0, level_o=0, xfer_cnt_o=0.
- Streaming: FIFO preloaded with 0x01..0x08, m_ready_i=1 →
  - r_en_o=1 from cycle 0.
  - m_valid_o from cycle 1.
  - Outputs 0x01..0x08 on consecutive cycles.
  - level_o=1 in steady state; xfer_cnt_o=8 at the end.
- Backpressure: FIFO holds 0xA0..0xA4, m_ready_i=0 →
  - exactly 2 pops; level_o=2; r_en_o=0 thereafter.
  - m_data_o=0xA0 stable.
  - Release ready → 0xA0..0xA4 delivered in order, none lost.
- Random ready: 64 random bytes, m_ready_i toggling pseudo-randomly →
  - output sequence equals input sequence.
  - r_en_o never high while level_o=2.
  - xfer_cnt_o=64.
- Flush: level_o=2 holding 0x11,0x22, FIFO head 0x33, flush_i pulsed 1 cycle with m_ready_i=0 →
  - next cycle m_valid_o=0; 0x33 not popped during the flush cycle.
  - Next word out is 0x33; xfer_cnt_o unchanged.
- Reset mid-stream and wrap:
  - rst_i asserted with level_o=2 → r_en_o=0 that cycle; next cycle all outputs at reset values.
  - With CNT_WIDTH=4, 17 transfers → xfer_cnt_o=1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: reader-side adapter for the async FIFO read port.
// Pops words from the show-ahead FIFO interface into a 2-entry registered
// buffer and presents them as a valid/ready stream. The pop decision looks
// only at the registered buffer count, so m_ready_i has no combinational
// path to r_en_o. Also provides a synchronous flush and a delivered-word count.
module fifo_rd_stream #(
    parameter type         data_t    = logic [7:0],
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  data_t                r_data_i,
    input  logic                 r_empty_i,
    output logic                 r_en_o,
    output data_t                m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    input  logic                 flush_i,
    output logic [1:0]           level_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

    data_t      buf_q [2];
    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       hs;

    // Pop only when the buffer has room; reset and flush both suppress the
    // pop so no FIFO word is consumed and then thrown away.
    assign r_en_o    = !rst_i && !r_empty_i && !flush_i && (count < 2'd2);
    assign m_valid_o = (count != 2'd0);
    assign m_data_o  = buf_q[head];
    assign level_o   = count;
    assign hs        = m_valid_o && m_ready_i;

    // Buffer storage: the popped FIFO head is written at the tail slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (r_en_o) begin
            buf_q[tail] <= r_data_i;
        end
    end

    // Head/tail pointers and occupancy; flush drops every buffered word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush_i) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (r_en_o) begin
                tail <= ~tail;
            end
            if (hs) begin
                head <= ~head;
            end
            count <= count + {1'b0, r_en_o} - {1'b0, hs};
        end
    end

    // Delivered-word counter; a handshake in a flush cycle still counts
    // because the consumer did take that word. Wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_cnt_o <= '0;
        end else if (hs) begin
            xfer_cnt_o <= xfer_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule
